// File: rtl/hls2x8_mac_pipe.sv
// Pipelined signed multiply / multiply-accumulate with scaled, saturating or wrapping output
// and valid/ready backpressure on both sides.
module hls2x8_mac_pipe #(
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 16,
   parameter int DOUT_WIDTH = 16,
   parameter int ACC_WIDTH  = DIN0_WIDTH + DIN1_WIDTH + 8,
   parameter int NUM_STAGE  = 3,
   parameter int FRAC_SHIFT = 0,
   parameter bit SAT        = 1'b1
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic signed [DIN1_WIDTH-1:0] din1,
   input  logic                         in_acc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic                         out_ovf
);

   localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;
   localparam int MID_N  = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 1;
   localparam logic signed [ACC_WIDTH-1:0] DOUT_MAX =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] DOUT_MIN =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   function automatic logic fits_dout(input logic signed [ACC_WIDTH-1:0] s);
      return (s >= DOUT_MIN) && (s <= DOUT_MAX);
   endfunction

   function automatic logic signed [DOUT_WIDTH-1:0] narrow_dout(input logic signed [ACC_WIDTH-1:0] s);
      if (SAT && (s > DOUT_MAX))
         return DOUT_MAX[DOUT_WIDTH-1:0];
      else if (SAT && (s < DOUT_MIN))
         return DOUT_MIN[DOUT_WIDTH-1:0];
      else
         return s[DOUT_WIDTH-1:0];
   endfunction

   logic                          w_ce;
   logic signed [PROD_W-1:0]      w_prod_fin;
   logic                          w_accf_fin;
   logic                          w_vld_fin;
   logic signed [ACC_WIDTH-1:0]   w_prod_ext;
   logic signed [ACC_WIDTH-1:0]   w_acc_next;
   logic signed [ACC_WIDTH-1:0]   w_scaled;
   logic signed [DOUT_WIDTH-1:0]  w_dout_next;
   logic                          w_ovf_next;

   logic                          r_vld_pn;
   logic signed [ACC_WIDTH-1:0]   r_acc_pn;
   logic signed [DOUT_WIDTH-1:0]  r_dout_pn;
   logic                          r_ovf_pn;

   // A full output register that is not being drained freezes the whole pipe.
   assign w_ce     = !(r_vld_pn && !out_ready);
   assign in_ready = w_ce;

   generate
      if (NUM_STAGE == 1) begin : g_one
         logic signed [PROD_W-1:0] w_a_x;
         logic signed [PROD_W-1:0] w_b_x;
         assign w_a_x      = PROD_W'(din0);
         assign w_b_x      = PROD_W'(din1);
         assign w_prod_fin = w_a_x * w_b_x;
         assign w_accf_fin = in_acc;
         assign w_vld_fin  = in_valid;
      end else begin : g_multi
         logic signed [DIN0_WIDTH-1:0] r_a_p1;
         logic signed [DIN1_WIDTH-1:0] r_b_p1;
         logic                         r_accf_p1;
         logic                         r_vld_p1;
         logic signed [PROD_W-1:0]     w_a_x;
         logic signed [PROD_W-1:0]     w_b_x;
         logic signed [PROD_W-1:0]     w_prod_p1;

         // Stage 1: operand capture
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n)
               r_vld_p1 <= 1'b0;
            else if (w_ce)
               r_vld_p1 <= in_valid;
         end

         always_ff @(posedge ap_clk) begin
            if (w_ce) begin
               r_a_p1    <= din0;
               r_b_p1    <= din1;
               r_accf_p1 <= in_acc;
            end
         end

         assign w_a_x     = PROD_W'(r_a_p1);
         assign w_b_x     = PROD_W'(r_b_p1);
         assign w_prod_p1 = w_a_x * w_b_x;

         if (NUM_STAGE == 2) begin : g_direct
            assign w_prod_fin = w_prod_p1;
            assign w_accf_fin = r_accf_p1;
            assign w_vld_fin  = r_vld_p1;
         end else begin : g_mid
            logic signed [PROD_W-1:0] r_prod_pm [MID_N];
            logic                     r_accf_pm [MID_N];
            logic                     r_vld_pm  [MID_N];

            // Middle stages: product transport
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
               if (!ap_rst_n) begin
                  for (int i = 0; i < MID_N; i++)
                     r_vld_pm[i] <= 1'b0;
               end else if (w_ce) begin
                  r_vld_pm[0] <= r_vld_p1;
                  for (int i = 1; i < MID_N; i++)
                     r_vld_pm[i] <= r_vld_pm[i-1];
               end
            end

            always_ff @(posedge ap_clk) begin
               if (w_ce) begin
                  r_prod_pm[0] <= w_prod_p1;
                  r_accf_pm[0] <= r_accf_p1;
                  for (int i = 1; i < MID_N; i++) begin
                     r_prod_pm[i] <= r_prod_pm[i-1];
                     r_accf_pm[i] <= r_accf_pm[i-1];
                  end
               end
            end

            assign w_prod_fin = r_prod_pm[MID_N-1];
            assign w_accf_fin = r_accf_pm[MID_N-1];
            assign w_vld_fin  = r_vld_pm[MID_N-1];
         end
      end
   endgenerate

   assign w_prod_ext  = ACC_WIDTH'(w_prod_fin);
   assign w_acc_next  = w_accf_fin ? (r_acc_pn + w_prod_ext) : w_prod_ext;
   assign w_scaled    = w_acc_next >>> FRAC_SHIFT;
   assign w_dout_next = narrow_dout(w_scaled);
   assign w_ovf_next  = !fits_dout(w_scaled);

   // Final stage: accumulate, scale, narrow; acc keeps the unsaturated sum
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_vld_pn  <= 1'b0;
         r_acc_pn  <= '0;
         r_dout_pn <= '0;
         r_ovf_pn  <= 1'b0;
      end else if (w_ce) begin
         r_vld_pn <= w_vld_fin;
         if (w_vld_fin) begin
            r_acc_pn  <= w_acc_next;
            r_dout_pn <= w_dout_next;
            r_ovf_pn  <= w_ovf_next;
         end
      end
   end

   assign out_valid = r_vld_pn;
   assign dout      = r_dout_pn;
   assign out_ovf   = r_ovf_pn;

endmodule

// File: tb/tb_hls2x8_mac_pipe.sv
// Directed bench for hls2x8_mac_pipe: three instances (default, wrapping, FRAC_SHIFT=8)
// share one input stream so each scenario checks all narrowing variants at once.
module tb_hls2x8_mac_pipe;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid, in_acc, out_ready;
   logic signed [15:0] din0, din1;

   logic rdy_d, vld_d, ovf_d;
   logic rdy_w, vld_w, ovf_w;
   logic rdy_f, vld_f, ovf_f;
   logic signed [15:0] dout_d, dout_w, dout_f;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hls2x8_mac_pipe u_def (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_d),
      .din0(din0), .din1(din1), .in_acc(in_acc), .out_valid(vld_d),
      .out_ready(out_ready), .dout(dout_d), .out_ovf(ovf_d));

   hls2x8_mac_pipe #(.SAT(1'b0)) u_wrap (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w),
      .din0(din0), .din1(din1), .in_acc(in_acc), .out_valid(vld_w),
      .out_ready(out_ready), .dout(dout_w), .out_ovf(ovf_w));

   hls2x8_mac_pipe #(.FRAC_SHIFT(8)) u_frac (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_f),
      .din0(din0), .din1(din1), .in_acc(in_acc), .out_valid(vld_f),
      .out_ready(out_ready), .dout(dout_f), .out_ovf(ovf_f));

   task automatic issue(input logic signed [15:0] a, input logic signed [15:0] b, input logic acc);
      din0 = a; din1 = b; in_acc = acc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_acc = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; #2;
      total++;
      if ({vld_d, ovf_d, dout_d} !== 18'h0) begin
         bad++; $display("FAIL reset_def got=%h exp=0", {vld_d, ovf_d, dout_d});
      end
      total++;
      if ({vld_w, vld_f, ovf_w, ovf_f, dout_w, dout_f} !== 36'h0) begin
         bad++; $display("FAIL reset_others got=%h exp=0", {vld_w, vld_f, ovf_w, ovf_f, dout_w, dout_f});
      end
      @(posedge clk); #1;
      rst_n = 1'b1; #1;
      total++;
      if ({rdy_d, rdy_w, rdy_f} !== 3'b111) begin
         bad++; $display("FAIL reset_in_ready got=%b exp=111", {rdy_d, rdy_w, rdy_f});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      issue(16'sd300, 16'sd200, 1'b0);
      @(posedge clk); #1;
      total++;
      if (vld_d !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", vld_d); end
      @(posedge clk); #1;
      total++;
      if ({vld_d, ovf_d, dout_d} !== {1'b1, 1'b1, 16'sd32767}) begin
         bad++; $display("FAIL sat_hi got=%b/%b/%0d exp=1/1/32767", vld_d, ovf_d, dout_d);
      end
      total++;
      if ({ovf_w, dout_w} !== {1'b1, -16'sd5536}) begin
         bad++; $display("FAIL wrap_300x200 got=%b/%0d exp=1/-5536", ovf_w, dout_w);
      end
      total++;
      if ({ovf_f, dout_f} !== {1'b0, 16'sd234}) begin
         bad++; $display("FAIL frac_300x200 got=%b/%0d exp=0/234", ovf_f, dout_f);
      end
      @(posedge clk); #1;
      total++;
      if (vld_d !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", vld_d); end
      issue(-16'sd3, 16'sd7, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if ({vld_d, ovf_d, dout_d} !== {1'b1, 1'b0, -16'sd21}) begin
         bad++; $display("FAIL neg_prod got=%b/%b/%0d exp=1/0/-21", vld_d, ovf_d, dout_d);
      end
      total++;
      if ({dout_w, dout_f} !== {-16'sd21, -16'sd1}) begin
         bad++; $display("FAIL neg_prod_var got=%0d/%0d exp=-21/-1", dout_w, dout_f);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_accum();
      logic signed [15:0] exp_d [4] = '{16'sd10000, 16'sd20000, 16'sd30000, 16'sd32767};
      logic signed [15:0] exp_w [4] = '{16'sd10000, 16'sd20000, 16'sd30000, -16'sd25536};
      logic signed [15:0] exp_f [4] = '{16'sd39, 16'sd78, 16'sd117, 16'sd156};
      logic               exp_o [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         issue(16'sd100, 16'sd100, logic'(i != 0));
         @(posedge clk); #1;
         @(posedge clk); #1;
         total++;
         if ({vld_d, ovf_d, dout_d} !== {1'b1, exp_o[i], exp_d[i]}) begin
            bad++; $display("FAIL acc_def[%0d] got=%b/%b/%0d exp=1/%b/%0d", i, vld_d, ovf_d, dout_d, exp_o[i], exp_d[i]);
         end
         total++;
         if ({ovf_w, dout_w, dout_f} !== {exp_o[i], exp_w[i], exp_f[i]}) begin
            bad++; $display("FAIL acc_var[%0d] got=%b/%0d/%0d exp=%b/%0d/%0d", i, ovf_w, dout_w, dout_f, exp_o[i], exp_w[i], exp_f[i]);
         end
      end
      issue(16'sd1, 16'sd1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if ({vld_d, ovf_d, dout_d, dout_f} !== {1'b1, 1'b0, 16'sd1, 16'sd0}) begin
         bad++; $display("FAIL acc_restart got=%b/%b/%0d/%0d exp=1/0/1/0", vld_d, ovf_d, dout_d, dout_f);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      issue(-16'sd128, 16'sd256, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if ({ovf_w, dout_w} !== {1'b0, -16'sd32768}) begin
         bad++; $display("FAIL wrap_min got=%b/%0d exp=0/-32768", ovf_w, dout_w);
      end
      total++;
      if ({ovf_d, dout_d, ovf_f, dout_f} !== {1'b0, -16'sd32768, 1'b0, -16'sd128}) begin
         bad++; $display("FAIL min_var got=%b/%0d/%b/%0d exp=0/-32768/0/-128", ovf_d, dout_d, ovf_f, dout_f);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_frac();
      issue(16'sh0100, 16'sh0180, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if ({ovf_f, dout_f} !== {1'b0, 16'sh0180}) begin
         bad++; $display("FAIL frac_scale got=%b/%h exp=0/0180", ovf_f, dout_f);
      end
      total++;
      if ({ovf_d, dout_d, ovf_w, dout_w} !== {1'b1, 16'sd32767, 1'b1, -16'sd32768}) begin
         bad++; $display("FAIL frac_var got=%b/%0d/%b/%0d exp=1/32767/1/-32768", ovf_d, dout_d, ovf_w, dout_w);
      end
      issue(-16'sd1, 16'sd1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if ({ovf_f, dout_f, dout_d} !== {1'b0, -16'sd1, -16'sd1}) begin
         bad++; $display("FAIL frac_floor got=%b/%0d/%0d exp=0/-1/-1", ovf_f, dout_f, dout_d);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      logic signed [15:0] held = '0;
      logic stalled = 1'b0;
      while (got < 8 && cyc < 300) begin
         out_ready = logic'($urandom_range(0, 1));
         in_valid  = (sent < 8);
         din0      = 16'(sent);
         din1      = 16'sd2;
         in_acc    = 1'b0;
         #3;
         total++;
         if (rdy_d !== !(vld_d && !out_ready)) begin
            bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, rdy_d, !(vld_d && !out_ready));
         end
         if (stalled) begin
            total++;
            if ({vld_d, dout_d} !== {1'b1, held}) begin
               bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d exp=1/%0d", cyc, vld_d, dout_d, held);
            end
         end
         if (vld_d && out_ready) begin
            total++;
            if (dout_d !== 16'(2 * got)) begin
               bad++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", got, dout_d, 2 * got);
            end
            got++;
         end
         stalled = vld_d && !out_ready;
         held    = dout_d;
         if (in_valid && rdy_d) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      total++;
      if (got != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", got); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++;
         if (vld_d !== 1'b0) begin bad++; $display("FAIL bp_extra cyc=%0d got=%b exp=0", i, vld_d); end
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din0 = 16'(7 + i); din1 = 16'sd7; in_acc = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if ({vld_d, dout_d} !== {1'b1, 16'sd49}) begin
         bad++; $display("FAIL rm_first got=%b/%0d exp=1/49", vld_d, dout_d);
      end
      rst_n = 1'b0; #1;
      total++;
      if ({vld_d, ovf_d, dout_d, vld_w, vld_f} !== 20'h0) begin
         bad++; $display("FAIL rm_async got=%h exp=0", {vld_d, ovf_d, dout_d, vld_w, vld_f});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++;
         if (vld_d !== 1'b0) begin bad++; $display("FAIL rm_flushed cyc=%0d got=%b exp=0", i, vld_d); end
      end
      issue(16'sd5, 16'sd5, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if ({vld_d, ovf_d, dout_d, dout_f} !== {1'b1, 1'b0, 16'sd25, 16'sd0}) begin
         bad++; $display("FAIL rm_acc_clear got=%b/%b/%0d/%0d exp=1/0/25/0", vld_d, ovf_d, dout_d, dout_f);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_acc    = 1'b0;
      out_ready = 1'b1;
      din0      = '0;
      din1      = '0;
      test_reset();
      test_single();
      test_accum();
      test_wrap();
      test_frac();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/hls2x8_mac_pipe.md
# hls2x8_mac_pipe

Pipelined, parametrised signed multiply / multiply-accumulate unit for the HLS2x8 datapath. It is the successor to the single-cycle truncating 16×16 multiplier.
- Operand and result widths and pipeline depth are configurable.
- An in-band accumulate mode is added.
- The output is a scaled result that either saturates or wraps.
- Valid/ready handshakes with full backpressure sit on both sides.

It sits between the operand fetch stage and the writeback buffer.

## Interface
- DIN0_WIDTH, 16: signed width of operand a.
- DIN1_WIDTH, 16: signed width of operand b.
- DOUT_WIDTH, 16: signed result width.
- ACC_WIDTH, DIN0_WIDTH+DIN1_WIDTH+8: internal accumulator width, with 8 guard bits.
- NUM_STAGE, 3: latency in cycles from acceptance to out_valid. Must be ≥1.
- FRAC_SHIFT, 0: arithmetic right shift applied before narrowing. Range 0..ACC_WIDTH-1.
- SAT, 1: 1 = saturate to DOUT range; 0 = wrap (keep low DOUT_WIDTH bits).

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- din0  in  DIN0_WIDTH  signed operand a.
- din1  in  DIN1_WIDTH  signed operand b.
- in_acc  in  1  0 = start a new sum (result = product); 1 = add the product to the running accumulator.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- dout  out  DOUT_WIDTH  scaled, narrowed result.
- out_ovf  out  1  the result was clipped (SAT=1) or wrapped (SAT=0) in narrowing.

## Operation
- Product: p = din0 × din1, full width DIN0+DIN1, signed, exact.
- Accumulator update happens in the final stage, in acceptance order:
  - acc_next = in_acc ? acc + sext(p) : sext(p);
  - arithmetic is modulo 2^ACC_WIDTH;
  - acc is loaded only when a valid beat passes through the final stage.
- Scaling: s = acc_next >>> FRAC_SHIFT. This is arithmetic, i.e. floor, with no rounding.
- Narrowing when SAT=1:
  - s > 2^(DOUT-1)-1 gives dout = 2^(DOUT-1)-1 and out_ovf=1;
  - s < -2^(DOUT-1) gives dout = -2^(DOUT-1) and out_ovf=1;
  - otherwise dout = s and out_ovf=0.
- Narrowing when SAT=0: dout = s[DOUT_WIDTH-1:0]. out_ovf=1 iff s does not fit in DOUT_WIDTH signed bits.
- The accumulator always keeps the unsaturated acc_next. Saturation affects the output only.
- One output beat per accepted input beat, in order. No beat is dropped or duplicated.
- Pipeline structure:
  - stage 1 registers the operands and in_acc;
  - middle stages carry the product, each with its own valid bit;
  - the last stage performs accumulate, scale and narrow into the output registers.
  - With NUM_STAGE=1, all of this is one registered stage.
- Stall:
  - ce = !(out_valid && !out_ready);
  - in_ready = ce;
  - when ce=0, every stage register, every valid bit and acc hold their values.
- Bubbles: invalid stage slots advance when ce=1. They never touch acc.

## Timing
- Reset (async assert, sync release): all stage valid bits = 0, acc = 0, dout = 0, out_ovf = 0, out_valid = 0. in_ready = 1 once reset is released.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+NUM_STAGE-1, assuming no stall. Each stall cycle adds exactly 1.
- Throughput: 1 beat/cycle while out_ready=1.
- dout and out_ovf are stable while out_valid && !out_ready.
- in_ready is combinational from out_ready and out_valid. There is no combinational path from in_valid to any output.
- Same-edge events:
  - out handshake plus in handshake in one cycle: both complete, and the pipeline advances by one;
  - in_acc=0 beat following an in_acc=1 beat: the new sum starts from the product, independent of the previous acc.
- Reset mid-operation: all in-flight beats are discarded, acc is cleared, and no partial result is emitted.
- First beat after reset with in_acc=1: it accumulates onto acc=0, so the result equals the product.

## Test plan
- Defaults, single beat: 300×200, in_acc=0 → dout=32767, out_ovf=1. Then -3×7 → dout=-21, out_ovf=0. out_valid rises NUM_STAGE-1 cycles after each acceptance edge.
- Accumulate chain, defaults: 100×100 with in_acc=0,1,1,1 → dout 10000, 20000, 30000, then 32767 with out_ovf=1. A fifth beat 1×1 with in_acc=0 → dout=1.
- SAT=0: 300×200 → dout=-5536, out_ovf=1. -128×256 → dout=-32768, out_ovf=0.
- FRAC_SHIFT=8: 0x0100×0x0180 → dout=0x0180. -1×1 → dout=-1 (floor, not 0).
- Backpressure: stream 8 beats with din0=i, din1=2 (i=0..7) while out_ready toggles randomly → outputs 0,2,…,14 in order. dout is held while stalled. in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-stream: assert ap_rst_n low while 3 beats are in flight → out_valid=0 and dout=0 immediately. After release, 5×5 with in_acc=1 → dout=25.
